// File: rtl/fpu_pkg.sv
// Shared floating-point definitions: exponent bias, special encodings,
// the unpacked single-precision view and the square-root datapath sizes.
package fpu_pkg;

    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    // Root datapath: 48-bit radicand, 24 root bits plus one round bit.
    localparam int RAD_BITS     = 48;
    localparam int ROOT_BITS    = 25;
    // Signed partial remainder; two spare bits above the largest magnitude.
    localparam int REM_BITS     = 30;
    // Iterations done before the pipeline register; the rest follow it.
    localparam int STAGE1_STEPS = 13;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } float_t;

    function automatic logic is_nan(input float_t f);
        return (f.exp == 8'hFF) && (f.man != 23'd0);
    endfunction

endpackage

// File: rtl/fsqrt_root.sv
// Slice of a non-restoring digit-by-digit integer square root.
// The radicand is treated as {rad, 2'b00} so 25 iterations yield 24 integer
// root bits plus one fractional (round) bit. FIRST/STEPS select which
// iterations this instance performs; partial root and remainder are chained
// in and out so the iterations can straddle a pipeline register.
module fsqrt_root
    import fpu_pkg::*;
#(
    parameter int FIRST = 0,
    parameter int STEPS = 25
) (
    input  logic [RAD_BITS-1:0]  rad,
    input  logic [ROOT_BITS-1:0] root_in,
    input  logic [REM_BITS-1:0]  rem_in,
    output logic [ROOT_BITS-1:0] root,
    output logic [REM_BITS-1:0]  rem_out
);

    localparam int RW = REM_BITS;

    logic [RAD_BITS+1:0] d50;
    logic                rad_unused;

    assign d50 = {rad, 2'b00};
    // Each slice only consumes its own bit pairs of the radicand.
    assign rad_unused = ^d50;

    for (genvar gi = 0; gi < STEPS; gi++) begin : g_iter
        localparam int LSB = RAD_BITS - 2 * (FIRST + gi);

        logic [ROOT_BITS-1:0] q_prev;
        logic [ROOT_BITS-1:0] q_next;
        logic [RW-1:0]        r_prev;
        logic [RW-1:0]        r_next;
        logic [RW-1:0]        shifted;
        logic [1:0]           pair;
        logic                 bits_unused;

        if (gi == 0) begin : g_head
            assign q_prev = root_in;
            assign r_prev = rem_in;
        end else begin : g_chain
            assign q_prev = g_iter[gi-1].q_next;
            assign r_prev = g_iter[gi-1].r_next;
        end

        assign pair        = d50[LSB +: 2];
        assign shifted     = {r_prev[RW-3:0], pair};
        // Headroom bit below the sign never carries information.
        assign bits_unused = r_prev[RW-2];

        // Negative remainder: add 4Q+3; otherwise subtract 4Q+1.
        assign r_next = r_prev[RW-1]
                      ? shifted + {{(RW-ROOT_BITS-2){1'b0}}, q_prev, 2'b11}
                      : shifted - {{(RW-ROOT_BITS-2){1'b0}}, q_prev, 2'b01};
        assign q_next = {q_prev[ROOT_BITS-2:0], ~r_next[RW-1]};
    end

    assign root    = g_iter[STEPS-1].q_next;
    assign rem_out = g_iter[STEPS-1].r_next;

endmodule

// File: rtl/fsqrt.sv
// Two-stage pipelined IEEE-754 single-precision square root.
// Stage 1 decodes the operand, classifies special inputs, forms the
// radicand and runs the first root iterations. Stage 2 finishes the root,
// rounds to nearest and lets a special-case result override the datapath.
module fsqrt #(
    parameter int BIAS = fpu_pkg::BIAS
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x,
    input  logic        x_valid,
    output logic [31:0] y,
    output logic        exception,
    output logic        y_valid
);

    localparam int          RW     = fpu_pkg::REM_BITS;
    localparam int          QW     = fpu_pkg::ROOT_BITS;
    localparam int          S1     = fpu_pkg::STAGE1_STEPS;
    localparam logic [8:0]  BIAS9  = 9'(BIAS);

    fpu_pkg::float_t xf;
    logic [8:0]      exp_sum;
    logic [47:0]     rad;
    logic            spec;
    logic [31:0]     spec_y;
    logic            spec_exc;
    logic [QW-1:0]   q1;
    logic [RW-1:0]   r1;

    logic            s1_valid_reg;
    logic            s1_spec_reg;
    logic [31:0]     s1_spec_y_reg;
    logic            s1_spec_exc_reg;
    logic [7:0]      s1_exp_reg;
    logic [47:0]     s1_rad_reg;
    logic [QW-1:0]   s1_root_reg;
    logic [RW-1:0]   s1_rem_reg;

    logic [QW-1:0]   q2;
    logic [RW-1:0]   rem_unused;
    logic            lead_unused;
    logic [23:0]     man_rnd;
    logic [7:0]      res_exp;
    logic [31:0]     res_next;

    assign xf = x;

    // floor((exp-BIAS)/2)+BIAS == floor((exp+BIAS)/2); the low bit of the sum
    // is the parity of the unbiased exponent.
    assign exp_sum = {1'b0, xf.exp} + BIAS9;

    // Odd unbiased exponent: shift 1.man left one place so the halved
    // exponent is exact.
    assign rad = exp_sum[0] ? {1'b1, xf.man, 24'd0}
                            : {2'b01, xf.man, 23'd0};

    // Classify zero/subnormal, NaN, negative and +inf ahead of the datapath.
    always_comb begin
        spec     = 1'b1;
        spec_y   = 32'd0;
        spec_exc = 1'b0;
        if (xf.exp == 8'd0) begin
            spec_y = {xf.sign, 31'd0};
        end else if (fpu_pkg::is_nan(xf) || xf.sign) begin
            spec_y   = fpu_pkg::QNAN;
            spec_exc = 1'b1;
        end else if (xf.exp == 8'hFF) begin
            spec_y = fpu_pkg::POS_INF;
        end else begin
            spec = 1'b0;
        end
    end

    fsqrt_root #(
        .FIRST (0),
        .STEPS (S1)
    ) u_root_s1 (
        .rad     (rad),
        .root_in ({QW{1'b0}}),
        .rem_in  ({RW{1'b0}}),
        .root    (q1),
        .rem_out (r1)
    );

    // Stage 1 register: valid always tracks x_valid, payload loads on accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_reg    <= 1'b0;
            s1_spec_reg     <= 1'b0;
            s1_spec_y_reg   <= 32'd0;
            s1_spec_exc_reg <= 1'b0;
            s1_exp_reg      <= 8'd0;
            s1_rad_reg      <= 48'd0;
            s1_root_reg     <= '0;
            s1_rem_reg      <= '0;
        end else begin
            s1_valid_reg <= x_valid;
            if (x_valid) begin
                s1_spec_reg     <= spec;
                s1_spec_y_reg   <= spec_y;
                s1_spec_exc_reg <= spec_exc;
                s1_exp_reg      <= exp_sum[8:1];
                s1_rad_reg      <= rad;
                s1_root_reg     <= q1;
                s1_rem_reg      <= r1;
            end
        end
    end

    fsqrt_root #(
        .FIRST (S1),
        .STEPS (QW - S1)
    ) u_root_s2 (
        .rad     (s1_rad_reg),
        .root_in (s1_root_reg),
        .rem_in  (s1_rem_reg),
        .root    (q2),
        .rem_out (rem_unused)
    );

    // The leading root bit is always 1 (the hidden bit) and is dropped.
    assign lead_unused = q2[QW-1];

    // Round to nearest on the extra root bit; a carry out renormalises.
    always_comb begin
        man_rnd  = {1'b0, q2[23:1]} + {23'd0, q2[0]};
        res_exp  = man_rnd[23] ? s1_exp_reg + 8'd1 : s1_exp_reg;
        res_next = {1'b0, res_exp, (man_rnd[23] ? 23'd0 : man_rnd[22:0])};
    end

    // Output register: special-case result wins over the computed root.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y         <= 32'd0;
            exception <= 1'b0;
            y_valid   <= 1'b0;
        end else begin
            y_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                y         <= s1_spec_reg ? s1_spec_y_reg : res_next;
                exception <= s1_spec_reg & s1_spec_exc_reg;
            end
        end
    end

endmodule

// File: tb/tb_fsqrt.sv
// Self-checking bench for fsqrt: directed vectors with hand-computed results,
// a back-to-back random stream checked against a real-valued sqrt, and an
// asynchronous reset with operands in flight.
`timescale 1ns/1ps
module tb_fsqrt;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] x = 32'd0;
    logic        x_valid = 1'b0;
    logic [31:0] y;
    logic        exception;
    logic        y_valid;

    always #5 clk = ~clk;

    fsqrt #(.BIAS(127)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .x         (x),
        .x_valid   (x_valid),
        .y         (y),
        .exception (exception),
        .y_valid   (y_valid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Two-deep history of what was driven: slot 1 = last cycle, slot 2 = the
    // one whose result is due now.
    logic        v1 = 1'b0, v2 = 1'b0;
    logic [31:0] x1 = 32'd0, x2 = 32'd0;
    logic [31:0] ey1 = 32'd0, ey2 = 32'd0;
    logic        ee1 = 1'b0, ee2 = 1'b0;
    logic        rl1 = 1'b0, rl2 = 1'b0;
    string       t1 = "idle", t2 = "idle";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%08h want=%08h", tag, got, want);
    endtask

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        return m * (2.0 ** real'(e));
    endfunction

    function automatic logic rel_ok(input logic [31:0] xi, input logic [31:0] yo);
        real s;
        real d;
        if (yo[31] || yo[30:23] == 8'd0 || yo[30:23] == 8'hFF) return 1'b0;
        s = $sqrt(f2r(xi));
        d = f2r(yo) - s;
        if (d < 0.0) d = -d;
        return d < s * (2.0 ** -20.0);
    endfunction

    task automatic clear_history();
        v1 = 1'b0; v2 = 1'b0;
        t1 = "idle"; t2 = "idle";
    endtask

    // One clock: check the result due now, then drive the next operand.
    task automatic step(input logic vin, input logic [31:0] xin, input logic [31:0] ey,
                        input logic ee, input logic rl, input string tag);
        @(negedge clk);
        check({t2, ":vld"}, {31'd0, y_valid}, {31'd0, v2});
        if (v2) begin
            if (rl2) begin
                check({t2, ":rel"}, {31'd0, rel_ok(x2, y)}, 32'd1);
                check({t2, ":exc"}, {31'd0, exception}, 32'd0);
            end else begin
                check({t2, ":y"}, y, ey2);
                check({t2, ":exc"}, {31'd0, exception}, {31'd0, ee2});
            end
            $display("txn %-10s x=%08h y=%08h exc=%0b", t2, x2, y, exception);
        end
        v2 = v1; x2 = x1; ey2 = ey1; ee2 = ee1; rl2 = rl1; t2 = t1;
        v1 = vin; x1 = xin; ey1 = ey; ee1 = ee; rl1 = rl; t1 = tag;
        x_valid = vin;
        x = xin;
    endtask

    localparam int ND = 18;
    logic [31:0] dx [ND];
    logic [31:0] dy [ND];
    logic        de [ND];

    initial begin
        dx = '{32'h40800000, 32'h40000000, 32'h7F7FFFFF, 32'hBF800000, 32'h7FC00001,
               32'h7F800000, 32'h00000000, 32'h80000000, 32'h3F800000, 32'h41100000,
               32'h40A00000, 32'h3E800000, 32'h00800000, 32'h00400000, 32'h80400000,
               32'hFF800000, 32'h7FFFFFFF, 32'h40800000};
        dy = '{32'h40000000, 32'h3FB504F3, 32'h5F7FFFFF, 32'h7FC00000, 32'h7FC00000,
               32'h7F800000, 32'h00000000, 32'h80000000, 32'h3F800000, 32'h40400000,
               32'h400F1BBD, 32'h3F000000, 32'h20000000, 32'h00000000, 32'h80000000,
               32'h7FC00000, 32'h7FC00000, 32'h40000000};
        de = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b0};

        // Outputs held clear while reset is asserted.
        repeat (2) @(negedge clk);
        check("rst:y", y, 32'd0);
        check("rst:exc", {31'd0, exception}, 32'd0);
        check("rst:vld", {31'd0, y_valid}, 32'd0);
        rstn = 1'b1;

        // Idle then a back-to-back directed burst.
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "idle");
        for (int i = 0; i < ND; i++) begin
            step(1'b1, dx[i], dy[i], de[i], 1'b0, $sformatf("d%0d", i));
        end
        // A gap in the stream must show up as a gap in y_valid.
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "idle");
        step(1'b1, 32'h41100000, 32'h40400000, 1'b0, 1'b0, "gap9");
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "idle");

        // Back-to-back random stream over all normal exponents, both signs.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] r;
            r = {$urandom_range(0, 1) == 1, 8'($urandom_range(1, 254)), 23'($urandom)};
            if (r[31]) step(1'b1, r, 32'h7FC00000, 1'b1, 1'b0, $sformatf("rn%0d", i));
            else       step(1'b1, r, 32'd0,        1'b0, 1'b1, $sformatf("rp%0d", i));
        end
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "idle");
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "idle");
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "idle");

        // Two operands in flight, then asynchronous reset mid-cycle.
        step(1'b1, 32'h40800000, 32'h40000000, 1'b0, 1'b0, "preA");
        step(1'b1, 32'h40000000, 32'h3FB504F3, 1'b0, 1'b0, "preB");
        @(posedge clk);
        #2;
        check("inflight:vld", {31'd0, y_valid}, 32'd1);
        rstn = 1'b0;
        x_valid = 1'b0;
        #1;
        check("async:y", y, 32'd0);
        check("async:exc", {31'd0, exception}, 32'd0);
        check("async:vld", {31'd0, y_valid}, 32'd0);
        clear_history();
        repeat (2) @(posedge clk);
        #1;
        check("hold:vld", {31'd0, y_valid}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // No stale result after release; then a fresh operand flows through.
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "idle");
        step(1'b1, 32'h41100000, 32'h40400000, 1'b0, 1'b0, "post9");
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "idle");
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "idle");
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
